// File: rtl/mac_filter.sv
`timescale 1ns/1ps
// mac_filter: Ethernet receive filter on destination MAC (unicast table plus
// broadcast) and optionally Ethertype. Strips the 14-byte header and forwards
// payload+FCS of accepted frames with one cycle of latency. Keeps saturating
// accept/drop frame counters.
module mac_filter #(
   parameter int                     DATA_WIDTH   = 2,
   parameter int                     NUM_MACS     = 2,
   parameter logic [NUM_MACS*48-1:0] MAC_TABLE    = {48'h69695A065491, 48'h0},
   parameter bit                     ACCEPT_BCAST = 1'b1,
   parameter bit                     ETYPE_EN     = 1'b0,
   parameter logic [15:0]            ETYPE        = 16'h88B5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  promisc,
   input  logic                  axiiv,
   input  logic [DATA_WIDTH-1:0] axiid,
   output logic                  axiov,
   output logic [DATA_WIDTH-1:0] axiod,
   output logic [15:0]           accept_count,
   output logic [15:0]           drop_count
);

   localparam int DB = 48 / DATA_WIDTH;
   localparam int TB = 16 / DATA_WIDTH;
   localparam int CW = $clog2(DB + 1);

   typedef enum logic [2:0] {
      S_WAIT, S_IDLE, S_DEST, S_SRC, S_TYPE, S_FWD, S_DROP
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_MACS-1:0]     hit_q, hit_d;
   logic                    bc_q, bc_d;
   logic                    et_q, et_d;
   logic [15:0]             acc_q, acc_d;
   logic [15:0]             drp_q, drp_d;
   logic                    ov_q, ov_d;
   logic [DATA_WIDTH-1:0]   od_q, od_d;

   logic [NUM_MACS-1:0]     ent_hit;
   logic                    bc_hit, et_hit, et_now, accept;
   logic [47:0]             mac_sh;
   logic [15:0]             et_sh;
   int                      shift;

   // Per-beat comparison of the current beat against every table entry,
   // broadcast and the Ethertype; the beat counter selects the field slice.
   always_comb begin
      shift   = int'(cnt_q) * DATA_WIDTH;
      mac_sh  = '0;
      ent_hit = '0;
      for (int unsigned i = 0; i < NUM_MACS; i++) begin
         mac_sh     = MAC_TABLE[48*i +: 48] << shift;
         ent_hit[i] = (mac_sh[47 -: DATA_WIDTH] == axiid);
      end
      et_sh  = ETYPE << shift;
      et_hit = (et_sh[15 -: DATA_WIDTH] == axiid);
      bc_hit = (axiid == '1);
   end

   // Next-state, match flags, counters and registered output beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      bc_d    = bc_q;
      et_d    = et_q;
      acc_d   = acc_q;
      drp_d   = drp_q;
      ov_d    = 1'b0;
      od_d    = '0;
      et_now  = et_q & et_hit;
      accept  = (promisc | (|hit_q) | (ACCEPT_BCAST & bc_q)) & (!ETYPE_EN | et_now);

      if ((state_q != S_WAIT) && (state_q != S_IDLE) && !axiiv) begin
         // Frame end: exactly one counter moves, depending on where it ended.
         state_d = S_IDLE;
         cnt_d   = '0;
         if (state_q == S_FWD)
            acc_d = (acc_q == 16'hFFFF) ? acc_q : acc_q + 16'd1;
         else
            drp_d = (drp_q == 16'hFFFF) ? drp_q : drp_q + 16'd1;
      end else begin
         case (state_q)
            S_WAIT: if (!axiiv) state_d = S_IDLE;
            S_IDLE: begin
               if (axiiv) begin
                  // This beat is dest beat 0: flags start as its compare result.
                  state_d = S_DEST;
                  hit_d   = ent_hit;
                  bc_d    = bc_hit;
                  cnt_d   = CW'(1);
               end
            end
            S_DEST: begin
               hit_d = hit_q & ent_hit;
               bc_d  = bc_q & bc_hit;
               if (cnt_q == CW'(DB - 1)) begin
                  state_d = S_SRC;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_SRC: begin
               if (cnt_q == CW'(DB - 1)) begin
                  state_d = S_TYPE;
                  cnt_d   = '0;
                  et_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_TYPE: begin
               et_d = et_now;
               if (cnt_q == CW'(TB - 1)) begin
                  state_d = accept ? S_FWD : S_DROP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_FWD: begin
               ov_d = 1'b1;
               od_d = axiid;
            end
            default: ;
         endcase
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
         hit_q   <= '0;
         bc_q    <= 1'b0;
         et_q    <= 1'b0;
         acc_q   <= '0;
         drp_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         bc_q    <= bc_d;
         et_q    <= et_d;
         acc_q   <= acc_d;
         drp_q   <= drp_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

   assign axiov        = ov_q;
   assign axiod        = od_q;
   assign accept_count = acc_q;
   assign drop_count   = drp_q;

endmodule

// File: tb/tb_mac_filter.sv
`timescale 1ns/1ps
// Bench for mac_filter: an RMII instance with defaults and a GMII instance
// with Ethertype filtering; forwarded beats are checked against a queue.
module tb_mac_filter;

   localparam logic [47:0] MAC_A = 48'h69695A065491;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] UNK   = 48'h020000000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        promisc;
   logic        pro8;
   logic        v2, v8;
   logic [1:0]  d2;
   logic [7:0]  d8;
   logic        ov2, ov8;
   logic [1:0]  od2;
   logic [7:0]  od8;
   logic [15:0] acc2, drp2, acc8, drp8;

   int checks = 0;
   int errors = 0;
   int n2 = 0;
   int n8 = 0;
   int ea2 = 0, ed2 = 0, ea8 = 0, ed8 = 0;
   int base;
   logic [1:0] q2[$];
   logic [7:0] q8[$];

   always #5 clk = ~clk;

   mac_filter u2 (
      .clk(clk), .rst(rst), .promisc(promisc), .axiiv(v2), .axiid(d2),
      .axiov(ov2), .axiod(od2), .accept_count(acc2), .drop_count(drp2)
   );

   mac_filter #(.DATA_WIDTH(8), .ETYPE_EN(1'b1)) u8 (
      .clk(clk), .rst(rst), .promisc(pro8), .axiiv(v8), .axiid(d8),
      .axiov(ov8), .axiod(od8), .accept_count(acc8), .drop_count(drp8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // Drive one frame; expected output beats are queued as they are driven.
   task automatic send(input bit w8, input logic [47:0] dst, input logic [15:0] et,
                       input int nb, input bit acc, input int rst_at, input bit lat);
      logic [7:0] fr[$];
      logic [47:0] src;
      logic [7:0] tmp, first, val;
      logic [1:0] dd;
      int bpb, hdr, k;
      src = 48'h020000AABBCC;
      fr = {};
      for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
      fr.push_back(et[15:8]);
      fr.push_back(et[7:0]);
      for (int i = 0; i < nb; i++) fr.push_back(8'($urandom_range(0, 255)));
      bpb = w8 ? 1 : 4;
      hdr = 14 * bpb;
      k = 0;
      first = '0;
      for (int j = 0; j < fr.size(); j++) begin
         for (int s = 0; s < bpb; s++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && k == rst_at) begin
               rst = 1'b1;
               ea2 = 0; ed2 = 0; ea8 = 0; ed8 = 0;
            end
            if (rst_at >= 0 && k == rst_at + 10) rst = 1'b0;
            if (lat && k == hdr) chk("first_beat_early", w8 ? ov8 : ov2, 0);
            if (lat && k == hdr + 1) begin
               chk("first_beat_valid", w8 ? ov8 : ov2, 1);
               chk("first_beat_data", w8 ? od8 : {6'b0, od2}, first);
            end
            tmp = fr[j];
            dd  = tmp[7-2*s -: 2];
            val = w8 ? tmp : {6'b0, dd};
            if (k == hdr) first = val;
            if (w8) begin
               v8 = 1'b1;
               d8 = tmp;
            end else begin
               v2 = 1'b1;
               d2 = dd;
            end
            if (acc && k >= hdr && (rst_at < 0 || k <= rst_at - 2)) begin
               if (w8) q8.push_back(tmp);
               else    q2.push_back(dd);
            end
            k++;
         end
      end
      @(posedge clk);
      #1;
      v2 = 1'b0; d2 = '0; v8 = 1'b0; d8 = '0;
      if (rst_at < 0) begin
         if (w8) begin
            if (acc) ea8 = sat(ea8); else ed8 = sat(ed8);
         end else begin
            if (acc) ea2 = sat(ea2); else ed2 = sat(ed2);
         end
      end
   endtask

   task automatic runt(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         v2 = 1'b1;
         d2 = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      v2 = 1'b0;
      d2 = '0;
      ed2 = sat(ed2);
   endtask

   initial begin
      rst = 1'b1; promisc = 1'b0; pro8 = 1'b0;
      v2 = 1'b0; d2 = '0; v8 = 1'b0; d8 = '0;

      fork
         forever begin
            @(negedge clk);
            if (ov2) begin
               n2++;
               if (q2.size() == 0) chk("unexpected_beat2", 1, 0);
               else chk("data2", od2, q2.pop_front());
            end else begin
               chk("idle_zero2", od2, 0);
            end
            if (ov8) begin
               n8++;
               if (q8.size() == 0) chk("unexpected_beat8", 1, 0);
               else chk("data8", od8, q8.pop_front());
            end else begin
               chk("idle_zero8", od8, 0);
            end
         end
      join_none

      // Reset state
      idle(3);
      chk("rst_axiov", ov2, 0);
      chk("rst_accept", acc2, 0);
      chk("rst_drop", drp2, 0);
      chk("rst_axiov8", ov8, 0);
      rst = 1'b0;
      idle(2);

      // 1: table entry, 50 bytes -> 200 dibits
      base = n2;
      send(0, MAC_A, 16'h0800, 50, 1, -1, 1);
      idle(3);
      chk("t1_beats", n2 - base, 200);
      chk("t1_accept", acc2, ea2);
      chk("t1_drop", drp2, ed2);

      // 2: broadcast accepted, unknown unicast dropped, zero entry accepted
      base = n2;
      send(0, BCAST, 16'h0800, 50, 1, -1, 0);
      idle(3);
      chk("t2_bcast_beats", n2 - base, 200);
      base = n2;
      send(0, UNK, 16'h0800, 50, 0, -1, 0);
      idle(3);
      chk("t2_unk_beats", n2 - base, 0);
      chk("t2_accept", acc2, ea2);
      chk("t2_drop", drp2, ed2);
      send(0, 48'h0, 16'h0800, 10, 1, -1, 0);
      idle(3);
      chk("t2_entry0_accept", acc2, ea2);

      // 3: GMII with Ethertype filter
      base = n8;
      send(1, MAC_A, 16'h0800, 50, 0, -1, 0);
      idle(3);
      chk("t3_wrong_type_beats", n8 - base, 0);
      chk("t3_drop8", drp8, ed8);
      base = n8;
      send(1, MAC_A, 16'h88B5, 50, 1, -1, 1);
      idle(3);
      chk("t3_beats8", n8 - base, 50);
      chk("t3_accept8", acc8, ea8);
      send(1, UNK, 16'h88B5, 20, 0, -1, 0);
      idle(3);
      chk("t3_unk_drop8", drp8, ed8);
      chk("t3_unk_accept8", acc8, ea8);

      // 4: promiscuous, then runt followed by a 1-cycle gap and a good frame
      promisc = 1'b1;
      base = n2;
      send(0, UNK, 16'h0800, 50, 1, -1, 0);
      promisc = 1'b0;
      idle(3);
      chk("t4_promisc_beats", n2 - base, 200);
      base = n2;
      runt(20);
      send(0, MAC_A, 16'h0800, 60, 1, -1, 1);
      idle(3);
      chk("t4_after_runt_beats", n2 - base, 240);
      chk("t4_accept", acc2, ea2);
      chk("t4_drop", drp2, ed2);

      // 5: reset asserted mid-frame, next frame accepted normally
      base = n2;
      send(0, MAC_A, 16'h0800, 50, 1, 120, 0);
      idle(3);
      chk("t5_partial_beats", n2 - base, 63);
      chk("t5_accept_cleared", acc2, 0);
      chk("t5_drop_cleared", drp2, 0);
      base = n2;
      send(0, MAC_A, 16'h0800, 50, 1, -1, 1);
      idle(3);
      chk("t5_next_beats", n2 - base, 200);
      chk("t5_accept", acc2, ea2);
      chk("t5_drop", drp2, ed2);

      // 6: saturation of the accept counter
      force u2.acc_q = 16'hFFFF;
      idle(1);
      release u2.acc_q;
      ea2 = 65535;
      send(0, MAC_A, 16'h0800, 20, 1, -1, 0);
      idle(3);
      chk("t6_sat1", acc2, 16'hFFFF);
      send(0, BCAST, 16'h0800, 20, 1, -1, 0);
      idle(3);
      chk("t6_sat2", acc2, 16'hFFFF);
      chk("t6_drop", drp2, ed2);

      idle(2);
      chk("queue2_empty", q2.size(), 0);
      chk("queue8_empty", q8.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
